// File: rtl/lifo_stack_pkg.sv
// lifo_stack shared definitions: opcode encoding and capacity helper.
package lifo_stack_pkg;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  function automatic int lifo_cap(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// lifo_stack_mem: word array below the top register, sync write, async read.
// Second read port exists only when LIFO_STACK_PEEK_EN is defined.
module lifo_stack_mem
  import lifo_stack_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 31
) (
  input  logic                  clk,
`ifdef LIFO_STACK_PEEK_EN
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  output logic [DATA_WIDTH-1:0] o_pdata,
`endif
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Addresses past the last word only occur when the caller ignores the data.
  assign o_rdata = (int'(i_raddr) < DEPTH) ? r_mem[i_raddr] : '0;

`ifdef LIFO_STACK_PEEK_EN
  assign o_pdata = (int'(i_paddr) < DEPTH) ? r_mem[i_paddr] : '0;
`endif

endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: LIFO with registered top, occupancy and overflow/underflow pulses.
// Define LIFO_STACK_PEEK_EN to add the peek_idx/peek_data read port.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef LIFO_STACK_PEEK_EN
  input  logic [ADDR_WIDTH-1:0] peek_idx,
  output logic [DATA_WIDTH-1:0] peek_data,
`endif
  input  logic [DATA_WIDTH-1:0] pushd,
  input  logic                  push_en,
  input  logic                  pop_en,
  output logic [DATA_WIDTH-1:0] top,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  err_ovf,
  output logic                  err_udf
);

  localparam int CAP   = lifo_cap(ADDR_WIDTH);
  localparam int DEPTH = CAP - 1;
  localparam logic [ADDR_WIDTH:0] CAP_W = (ADDR_WIDTH+1)'(CAP);
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] TWO   = (ADDR_WIDTH+1)'(2);

  logic [DATA_WIDTH-1:0] r_top;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_ovf;
  logic                  r_udf;

  logic [1:0]            w_op;
  logic                  w_empty;
  logic                  w_full;
  logic [ADDR_WIDTH:0]   w_sp;
  logic [ADDR_WIDTH:0]   w_sp2;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_op    = {push_en, pop_en};
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CAP_W);
  assign w_sp    = r_count - ONE;
  assign w_sp2   = r_count - TWO;
  // Old top spills into the array only on a plain push that is accepted.
  assign w_we    = (w_op == OP_PUSH) && !w_empty && !w_full;

`ifdef LIFO_STACK_PEEK_EN
  logic [ADDR_WIDTH:0]   w_pidx;
  logic [ADDR_WIDTH:0]   w_paddr;
  logic [DATA_WIDTH-1:0] w_pdata;

  assign w_pidx  = {1'b0, peek_idx};
  assign w_paddr = w_sp - w_pidx;
  assign peek_data = (w_pidx >= r_count) ? '0 :
                     (w_pidx == '0)      ? r_top : w_pdata;
`endif

  lifo_stack_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
`ifdef LIFO_STACK_PEEK_EN
    .i_paddr (w_paddr[ADDR_WIDTH-1:0]),
    .o_pdata (w_pdata),
`endif
    .i_we    (w_we),
    .i_waddr (w_sp[ADDR_WIDTH-1:0]),
    .i_wdata (r_top),
    .i_raddr (w_sp2[ADDR_WIDTH-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_top   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      unique case (w_op)
        OP_PUSH: begin
          if (w_full) begin
            r_ovf <= 1'b1;
          end else begin
            r_top   <= pushd;
            r_count <= r_count + ONE;
          end
        end
        OP_POP: begin
          if (w_empty) begin
            r_udf <= 1'b1;
          end else begin
            r_top   <= (r_count == ONE) ? '0 : w_rdata;
            r_count <= w_sp;
          end
        end
        OP_REPL: begin
          r_top <= pushd;
          if (w_empty) r_count <= ONE;
        end
        default: ;
      endcase
    end
  end

  assign top     = r_top;
  assign count   = r_count;
  assign empty   = w_empty;
  assign full    = w_full;
  assign err_ovf = r_ovf;
  assign err_udf = r_udf;

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: queue-based reference model plus directed stimulus, CAP=4.
module tb_lifo_stack;

  localparam int DW  = 16;
  localparam int AW  = 2;
  localparam int CAP = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] pushd;
  logic          push_en;
  logic          pop_en;
  logic [DW-1:0] top;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          err_ovf;
  logic          err_udf;
`ifdef LIFO_STACK_PEEK_EN
  logic [AW-1:0] peek_idx;
  logic [DW-1:0] peek_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf;
  logic          m_udf;

  lifo_stack #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef LIFO_STACK_PEEK_EN
    .peek_idx  (peek_idx),
    .peek_data (peek_data),
`endif
    .pushd     (pushd),
    .push_en   (push_en),
    .pop_en    (pop_en),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .err_ovf   (err_ovf),
    .err_udf   (err_udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_top();
    return (q.size() > 0) ? q[q.size()-1] : '0;
  endfunction

  // Reference model: the queue tail is the top of stack.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
      case ({push_en, pop_en})
        2'b10: if (q.size() == CAP) m_ovf = 1'b1; else q.push_back(pushd);
        2'b01: if (q.size() == 0) m_udf = 1'b1; else void'(q.pop_back());
        2'b11: if (q.size() == 0) q.push_back(pushd); else q[q.size()-1] = pushd;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_top", 32'(top), 32'(m_top()));
      chk("m_count", 32'(count), q.size());
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_full", 32'(full), 32'(q.size() == CAP));
      chk("m_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("m_udf", 32'(err_udf), 32'(m_udf));
`ifdef LIFO_STACK_PEEK_EN
      chk("m_peek", 32'(peek_data),
          (int'(peek_idx) < q.size()) ? 32'(q[q.size()-1-int'(peek_idx)]) : 32'd0);
`endif
    end
  end

  task automatic apply(input logic p, input logic o, input logic [DW-1:0] d);
    @(negedge clk);
    #2;
    push_en = p;
    pop_en  = o;
    pushd   = d;
    @(posedge clk);
    #1;
    push_en = 1'b0;
    pop_en  = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    push_en = 1'b0;
    pop_en  = 1'b0;
    pushd   = '0;
`ifdef LIFO_STACK_PEEK_EN
    peek_idx = '0;
`endif
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_top", 32'(top), 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_errs", 32'({err_ovf, err_udf}), 32'd0);

    apply(1, 0, 16'h11);
    apply(1, 0, 16'h22);
    chk("pre_rst_top", 32'(top), 32'h22);
    chk("pre_rst_count", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_top", 32'(top), 32'h0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    #1 rst = 1'b0;
    apply(1, 0, 16'h33);
    chk("post_rst_top", 32'(top), 32'h33);
    chk("post_rst_count", 32'(count), 32'd1);
    apply(0, 1, 16'h0);

    apply(1, 0, 16'hA1);
    apply(1, 0, 16'hA2);
    apply(1, 0, 16'hA3);
    apply(1, 0, 16'hA4);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_top", 32'(top), 32'hA4);
    apply(1, 0, 16'hFF);
    chk("ovf_pulse", 32'(err_ovf), 32'd1);
    chk("ovf_top", 32'(top), 32'hA4);
    chk("ovf_count", 32'(count), 32'd4);
    apply(0, 0, 16'h0);
    chk("ovf_clear", 32'(err_ovf), 32'd0);
    apply(0, 1, 16'h0);
    chk("drain1", 32'(top), 32'hA3);
    apply(0, 1, 16'h0);
    chk("drain2", 32'(top), 32'hA2);
    apply(0, 1, 16'h0);
    chk("drain3", 32'(top), 32'hA1);
    apply(0, 1, 16'h0);
    chk("drain4", 32'(top), 32'h0);
    chk("drain_empty", 32'(empty), 32'd1);

    apply(0, 1, 16'h0);
    chk("udf_pulse", 32'(err_udf), 32'd1);
    chk("udf_count", 32'(count), 32'd0);
    chk("udf_top", 32'(top), 32'h0);
    apply(1, 0, 16'h05);
    chk("udf_push_top", 32'(top), 32'h05);
    chk("udf_push_err", 32'(err_udf), 32'd0);
    apply(0, 1, 16'h0);

    apply(1, 0, 16'h10);
    apply(1, 0, 16'h20);
    apply(1, 1, 16'h30);
    chk("repl_top", 32'(top), 32'h30);
    chk("repl_count", 32'(count), 32'd2);
    apply(0, 1, 16'h0);
    chk("repl_pop_top", 32'(top), 32'h10);
    apply(0, 1, 16'h0);
    apply(1, 1, 16'h40);
    chk("repl_empty_top", 32'(top), 32'h40);
    chk("repl_empty_count", 32'(count), 32'd1);
    chk("repl_empty_err", 32'({err_ovf, err_udf}), 32'd0);
    apply(0, 1, 16'h0);

`ifdef LIFO_STACK_PEEK_EN
    apply(1, 0, 16'h1);
    apply(1, 0, 16'h2);
    apply(1, 0, 16'h3);
    peek_idx = 2'd0; #1 chk("peek0", 32'(peek_data), 32'h3);
    peek_idx = 2'd1; #1 chk("peek1", 32'(peek_data), 32'h2);
    peek_idx = 2'd2; #1 chk("peek2", 32'(peek_data), 32'h1);
    peek_idx = 2'd3; #1 chk("peek3", 32'(peek_data), 32'h0);
    chk("peek_count", 32'(count), 32'd3);
`endif

    for (int i = 0; i < 120; i++) begin
`ifdef LIFO_STACK_PEEK_EN
      peek_idx = 2'($urandom_range(0, 3));
`endif
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 16'hFFFF)));
    end
    apply(0, 0, 16'h0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
Parametrised successor to the processor's loop-return stack. It is a LIFO with a registered top-of-stack and occupancy tracking (count, full, empty). It also supports simultaneous push+pop (replace top), and guards against overflow and underflow with error pulses. It sits beside the control unit and stores loop-start addresses; it is generic enough for any LIFO use in the design.

Parameters:
DATA_WIDTH, 16, width of each stored value
ADDR_WIDTH, 5, log2 of capacity; capacity CAP = 2^ADDR_WIDTH entries (top register included)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
pushd  input  DATA_WIDTH  data to push
push_en  input  1  push on this clock edge
pop_en  input  1  pop on this clock edge
top  output  DATA_WIDTH  current top-of-stack value, registered; 0 when empty
count  output  ADDR_WIDTH+1  number of valid entries, 0..CAP
empty  output  1  count == 0
full  output  1  count == CAP
err_ovf  output  1  one-cycle pulse: push rejected because full
err_udf  output  1  one-cycle pulse: pop rejected because empty

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async assert, any time, including mid-operation): top=0, count=0, empty=1, full=0, err_ovf=0, err_udf=0. Array contents are don't-care and not cleared.
- Storage: top lives in its own register; the entries below it live in an array of CAP-1 words indexed by pointer sp = count-1 (next free slot below top).
- Outputs top/count/empty/full/err_* are all registered and reflect operations from the previous edge; latency is 1 cycle.
- Operations per edge, decoded from {push_en, pop_en}:
  - 00 idle: no state change; err_* = 0.
  - 10 push:
    - empty: top<=pushd, count<=1.
    - 0<count<CAP: array[count-1]<=top, top<=pushd, count+1.
    - full: no change, err_ovf<=1.
  - 01 pop:
    - count>1: top<=array[count-2], count-1.
    - count==1: top<=0, count<=0.
    - empty: no change, err_udf<=1.
  - 11 replace: pops and pushes in the same edge.
    - count>=1: top<=pushd, count unchanged, array unchanged.
    - empty: acts as a plain push (top<=pushd, count<=1), no error.
- Pointer arithmetic is done at ADDR_WIDTH+1 bits; it never wraps because guards block overflow and underflow.
- full/empty are derived combinationally from the count register (no extra latency).
- The array read for pop is combinational from the array. For FPGA the array may map to distributed RAM; block RAM is not required.

Optional Feature:
- Macro: LIFO_STACK_PEEK_EN.
- Defined: adds input peek_idx [ADDR_WIDTH-1:0] and output peek_data [DATA_WIDTH-1:0].
  - peek_data is combinational: idx 0 = top, idx k = array[count-1-k].
  - peek_data = 0 when peek_idx >= count.
  - Peeking has no side effects.
- Undefined: neither port exists and no peek mux is built. All other behaviour is identical.

Decomposition:
- Shared package: opcode encoding constants (OP_IDLE=2'b00, OP_POP=2'b01, OP_PUSH=2'b10, OP_REPL=2'b11) and the function lifo_cap(ADDR_WIDTH).
- One sub-module is natural: lifo_stack_mem, a parametrised CAP-1 word array with synchronous write and asynchronous read.
  - The read port is used for pop; a second read port is used for peek when enabled.
  - Control, count and the top register stay in lifo_stack.

Test Plan:
- Reset mid-operation (ADDR_WIDTH=2, CAP=4): push 0x11, 0x22, assert rst asynchronously between edges -> immediately top=0, count=0, empty=1; next push 0x33 -> top=0x33, count=1.
- Fill and drain: push 0xA1,0xA2,0xA3,0xA4 -> full=1, count=4, top=0xA4; four pops -> top sequence 0xA3,0xA2,0xA1,0; empty=1 after last.
- Overflow: while full, push 0xFF -> err_ovf=1 for exactly one cycle, top stays 0xA4, count=4; the following idle cycle -> err_ovf=0.
- Underflow: from reset, pop -> err_udf=1 for one cycle, count=0, top=0; then push 0x05 -> top=0x05, no error.
- Replace: push 0x10, 0x20, then push_en=pop_en=1 with pushd=0x30 -> top=0x30, count=2; pop -> top=0x10. Replace on empty with 0x40 -> top=0x40, count=1.
- Peek (LIFO_STACK_PEEK_EN defined): push 1,2,3 -> peek_idx 0/1/2 give 3/2/1; peek_idx 3 gives 0.
